serial_frame_tx: RTL and testbench



---
 rtl/serial_frame_tx.sv | 163 ++++++++++++++++
 tb/tb_serial_frame_tx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: frames an N-bit parallel word as start bit, N data bits
// (LSB- or MSB-first, chosen per word) and stop bit, one bit per clock, to
// feed a serial shift-register chain through its D and enable inputs.
// Optional build macro SERIAL_FRAME_PARITY_EN inserts an even-parity bit
// between the last data bit and the stop bit.
module serial_frame_tx #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic         msb_first,
  output logic         sout,
  output logic         sout_en,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef SERIAL_FRAME_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t         state, state_n;
  logic [N-1:0]   shreg, shreg_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           order, order_n;
  logic           sout_n, sout_en_n, busy_n, done_n, ready_n;
`ifdef SERIAL_FRAME_PARITY_EN
  logic           par, par_n;
`endif

  // Next-state, datapath update and next-output decode.
  // Outputs are decoded from the *next* state and shift register so that the
  // registered outputs line up with the state they belong to.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    order_n = order;
`ifdef SERIAL_FRAME_PARITY_EN
    par_n   = par;
`endif

    unique case (state)
      S_IDLE: begin
        if (din_valid && din_ready) begin
          state_n = S_START;
          shreg_n = din;
          order_n = msb_first;
          cnt_n   = '0;
`ifdef SERIAL_FRAME_PARITY_EN
          par_n   = ^din;
`endif
        end
      end
      S_START: begin
        state_n = S_DATA;
      end
      S_DATA: begin
        shreg_n = order ? {shreg[N-2:0], 1'b0} : {1'b0, shreg[N-1:1]};
        cnt_n   = cnt + CW'(1);
        if (cnt == CW'(N - 1)) begin
`ifdef SERIAL_FRAME_PARITY_EN
          state_n = S_PARITY;
`else
          state_n = S_STOP;
`endif
        end
      end
`ifdef SERIAL_FRAME_PARITY_EN
      S_PARITY: begin
        state_n = S_STOP;
      end
`endif
      S_STOP: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    sout_n    = 1'b0;
    sout_en_n = 1'b0;
    busy_n    = 1'b0;
    done_n    = 1'b0;
    ready_n   = 1'b0;

    unique case (state_n)
      S_IDLE: begin
        ready_n = 1'b1;
      end
      S_START: begin
        sout_n    = 1'b1;
        sout_en_n = 1'b1;
        busy_n    = 1'b1;
      end
      S_DATA: begin
        sout_n    = order_n ? shreg_n[N-1] : shreg_n[0];
        sout_en_n = 1'b1;
        busy_n    = 1'b1;
      end
`ifdef SERIAL_FRAME_PARITY_EN
      S_PARITY: begin
        sout_n    = par_n;
        sout_en_n = 1'b1;
        busy_n    = 1'b1;
      end
`endif
      S_STOP: begin
        sout_n    = 1'b0;
        sout_en_n = 1'b1;
        busy_n    = 1'b1;
        done_n    = 1'b1;
      end
      default: begin
        ready_n = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      shreg     <= '0;
      cnt       <= '0;
      order     <= 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
      par       <= 1'b0;
`endif
      sout      <= 1'b0;
      sout_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      din_ready <= 1'b1;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      cnt       <= cnt_n;
      order     <= order_n;
`ifdef SERIAL_FRAME_PARITY_EN
      par       <= par_n;
`endif
      sout      <= sout_n;
      sout_en   <= sout_en_n;
      busy      <= busy_n;
      done      <= done_n;
      din_ready <= ready_n;
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: scoreboard bench for serial_frame_tx (N=4).
// Expected serial bits are queued when a word is handed over and compared
// against sout on every sout_en cycle.
module tb_serial_frame_tx;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         msb_first;
  logic         sout;
  logic         sout_en;
  logic         busy;
  logic         done;

  typedef struct {
    logic b;
    logic first;
    logic last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_stop = -100;
  int   gap_last = 0;

  serial_frame_tx #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .msb_first (msb_first),
    .sout      (sout),
    .sout_en   (sout_en),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_frame(input logic [N-1:0] word, input logic msb);
    exp_t e;
    e = '{b: 1'b1, first: 1'b1, last: 1'b0};
    sb.push_back(e);
    for (int i = 0; i < N; i++) begin
      e = '{b: (msb ? word[N-1-i] : word[i]), first: 1'b0, last: 1'b0};
      sb.push_back(e);
    end
`ifdef SERIAL_FRAME_PARITY_EN
    e = '{b: ^word, first: 1'b0, last: 1'b0};
    sb.push_back(e);
`endif
    e = '{b: 1'b0, first: 1'b0, last: 1'b1};
    sb.push_back(e);
  endtask

  // Drive a word and wait (bounded) for it to be accepted; optionally keep
  // din_valid asserted afterwards.
  task automatic send(input logic [N-1:0] word, input logic msb, input logic hold);
    int n;
    din       = word;
    msb_first = msb;
    din_valid = 1'b1;
    n = 0;
    while (!din_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!din_ready) check("ready_timeout", 32'd0, 32'd1);
    push_frame(word, msb);
    @(posedge clk); #1;
    msb_first = ~msb;
    if (!hold) din_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: compare every framed bit and the status outputs on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("busy_vs_en", busy, sout_en);
      check("ready_vs_busy", din_ready, !busy);
      if (sout_en) begin
        if (sb.size() == 0) begin
          check("unexpected_bit", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("sout", sout, e.b);
          check("done", done, e.last);
          if (e.first) gap_last = cyc - last_stop;
          if (e.last) last_stop = cyc;
        end
      end else begin
        check("done_idle", done, 1'b0);
        check("sout_idle", sout, 1'b0);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    din       = 4'hA;
    din_valid = 1'b1;
    msb_first = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("rst_sout", sout, 1'b0);
    check("rst_sout_en", sout_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", din_ready, 1'b1);
    din_valid = 1'b0;
    rst       = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("no_accept_in_rst", busy, 1'b0);

    // LSB-first and MSB-first single words
    send(4'b1011, 1'b0, 1'b0);
    wait_drain();
    send(4'b1011, 1'b1, 1'b0);
    wait_drain();

    // Back-to-back with valid held
    send(4'hA, 1'b0, 1'b1);
    send(4'h5, 1'b0, 1'b0);
    wait_drain();
    check("b2b_gap", gap_last, 2);

    // Valid while busy: din changes mid-frame, then is accepted in IDLE
    send(4'h3, 1'b1, 1'b1);
    repeat (2) begin
      @(posedge clk); #1;
    end
    din       = 4'hF;
    msb_first = 1'b0;
    send(4'hF, 1'b0, 1'b0);
    wait_drain();

    // Reset in the third DATA cycle
    send(4'h9, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    check("abort_sout_en", sout_en, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_ready", din_ready, 1'b1);
    check("abort_sout", sout, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    send(4'h6, 1'b1, 1'b0);
    wait_drain();

    // A few random words with random order and gaps
    for (int k = 0; k < 8; k++) begin
      send(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
